// File: rtl/soc_top.sv
// Demo SoC: mirrors switches/buttons onto LEDs and hex digits, and loops the switch
// word through a TX FIFO, an 8N1 UART and an RX FIFO into the LCD word.

module soc_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [7:0]                   wr_data,
    output logic [7:0]                   rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [7:0]    rd_data_reg;
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          empty_reg, full_reg, do_push, do_pop;

    assign do_push = push && !full_reg;
    assign do_pop  = pop && !empty_reg;

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop)
            count_next = count_reg + 1'b1;
        else if (do_pop && !do_push)
            count_next = count_reg - 1'b1;
    end

    // Storage has no reset so it maps onto RAM; read data appears the cycle after pop.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= wr_data;
        if (do_pop)
            rd_data_reg <= mem[rd_ptr_reg];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            empty_reg  <= 1'b1;
            full_reg   <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            empty_reg <= (count_next == '0);
            full_reg  <= (count_next == CW'(DEPTH));
        end
    end

    assign rd_data = rd_data_reg;
    assign count   = count_reg;
    assign empty   = empty_reg;
    assign full    = full_reg;
endmodule

module soc_top #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] sw,
    input  logic [3:0]  btn,
    output logic [31:0] pc_debug,
    output logic        instr_vld,
    output logic [31:0] ledr,
    output logic [31:0] ledg,
    output logic [31:0] lcd,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7,
    input  logic        UART_RX_I,
    output logic        UART_TX_O,
    output logic        tx_fifo_empty,
    output logic        tx_fifo_full,
    output logic        rx_fifo_empty,
    output logic        rx_fifo_full
);
    localparam int BIT_CYC  = CLK_FREQ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int TW       = $clog2(BIT_CYC + 1);
    localparam int FCW      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {SEQ_IDLE, SEQ_LOAD} seq_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [31:0] sw_meta_reg, sw_sync_reg, ledr_reg;
    logic [3:0]  btn_meta_reg, btn_sync_reg, ledg_reg;
    logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic [1:0]  settle_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_reg  <= '0;
            sw_sync_reg  <= '0;
            ledr_reg     <= '0;
            btn_meta_reg <= '0;
            btn_sync_reg <= '0;
            ledg_reg     <= '0;
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            settle_reg   <= '0;
        end else begin
            sw_meta_reg  <= sw;
            sw_sync_reg  <= sw_meta_reg;
            ledr_reg     <= sw_sync_reg;
            btn_meta_reg <= btn;
            btn_sync_reg <= btn_meta_reg;
            ledg_reg     <= btn_sync_reg;
            rx_meta_reg  <= UART_RX_I;
            rx_sync_reg  <= rx_meta_reg;
            rx_prev_reg  <= rx_sync_reg;
            // Hold off the first send until the synchronisers carry real switch values.
            if (settle_reg != 2'd3)
                settle_reg <= settle_reg + 2'd1;
        end
    end

    assign ledr = ledr_reg;
    assign ledg = {28'd0, ledg_reg};

    // Sequencer
    seq_state_t     seq_state_reg, seq_state_next;
    logic [31:0]    snapshot_reg, snapshot_next, last_sent_reg, last_sent_next, pc_reg, pc_next;
    logic           sent_valid_reg, sent_valid_next, btn_prev_reg, btn_pend_reg, btn_pend_next;
    logic [1:0]     byte_idx_reg, byte_idx_next;
    logic           btn_edge, send_pending, tx_room, tx_push;
    logic [7:0]     tx_wr_data;
    logic [FCW-1:0] tx_count;

    assign btn_edge     = btn_sync_reg[0] && !btn_prev_reg;
    assign send_pending = !sent_valid_reg || (sw_sync_reg != last_sent_reg) || btn_pend_reg || btn_edge;
    assign tx_room      = (FIFO_DEPTH - int'(tx_count)) >= 4;

    always_comb begin
        seq_state_next  = seq_state_reg;
        snapshot_next   = snapshot_reg;
        last_sent_next  = last_sent_reg;
        sent_valid_next = sent_valid_reg;
        pc_next         = pc_reg;
        byte_idx_next   = byte_idx_reg;
        btn_pend_next   = btn_pend_reg || btn_edge;
        tx_push         = 1'b0;
        tx_wr_data      = snapshot_reg[8*byte_idx_reg +: 8];
        case (seq_state_reg)
            SEQ_IDLE: begin
                if (settle_reg == 2'd3 && send_pending && tx_room) begin
                    seq_state_next  = SEQ_LOAD;
                    snapshot_next   = sw_sync_reg;
                    last_sent_next  = sw_sync_reg;
                    sent_valid_next = 1'b1;
                    btn_pend_next   = 1'b0;
                    byte_idx_next   = 2'd0;
                end
            end
            SEQ_LOAD: begin
                tx_push       = 1'b1;
                pc_next       = pc_reg + 32'd4;
                byte_idx_next = byte_idx_reg + 2'd1;
                if (byte_idx_reg == 2'd3)
                    seq_state_next = SEQ_IDLE;
            end
            default: seq_state_next = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_state_reg  <= SEQ_IDLE;
            snapshot_reg   <= '0;
            last_sent_reg  <= '0;
            sent_valid_reg <= 1'b0;
            pc_reg         <= '0;
            byte_idx_reg   <= '0;
            btn_pend_reg   <= 1'b0;
            btn_prev_reg   <= 1'b0;
        end else begin
            seq_state_reg  <= seq_state_next;
            snapshot_reg   <= snapshot_next;
            last_sent_reg  <= last_sent_next;
            sent_valid_reg <= sent_valid_next;
            pc_reg         <= pc_next;
            byte_idx_reg   <= byte_idx_next;
            btn_pend_reg   <= btn_pend_next;
            btn_prev_reg   <= btn_sync_reg[0];
        end
    end

    assign instr_vld = (seq_state_reg == SEQ_LOAD);
    assign pc_debug  = pc_reg;

    // UART transmitter: start bit is sent while the popped byte is still in flight from the FIFO.
    logic          tx_pop, tx_busy_reg, tx_load_reg, tx_line_reg, tx_bit_end, tx_frame_end;
    logic [7:0]    tx_rd_data, tx_shift_reg;
    logic [3:0]    tx_bit_reg;
    logic [TW-1:0] tx_cyc_reg;

    soc_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .wr_data(tx_wr_data),
        .rd_data(tx_rd_data), .count(tx_count), .empty(tx_fifo_empty), .full(tx_fifo_full)
    );

    assign tx_bit_end   = (tx_cyc_reg == TW'(BIT_CYC - 1));
    assign tx_frame_end = tx_bit_end && (tx_bit_reg == 4'd9);
    assign tx_pop       = !tx_fifo_empty && (!tx_busy_reg || tx_frame_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy_reg  <= 1'b0;
            tx_load_reg  <= 1'b0;
            tx_line_reg  <= 1'b1;
            tx_shift_reg <= '0;
            tx_bit_reg   <= '0;
            tx_cyc_reg   <= '0;
        end else begin
            tx_load_reg <= tx_pop;
            if (tx_load_reg)
                tx_shift_reg <= tx_rd_data;
            if (tx_pop) begin
                tx_busy_reg <= 1'b1;
                tx_bit_reg  <= '0;
                tx_cyc_reg  <= '0;
                tx_line_reg <= 1'b0;
            end else if (tx_frame_end) begin
                tx_busy_reg <= 1'b0;
                tx_line_reg <= 1'b1;
            end else if (tx_busy_reg) begin
                if (tx_bit_end) begin
                    tx_cyc_reg <= '0;
                    tx_bit_reg <= tx_bit_reg + 4'd1;
                    if (tx_bit_reg == 4'd8) begin
                        tx_line_reg <= 1'b1;
                    end else begin
                        tx_line_reg  <= tx_shift_reg[0];
                        tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                    end
                end else begin
                    tx_cyc_reg <= tx_cyc_reg + 1'b1;
                end
            end
        end
    end

    assign UART_TX_O = tx_line_reg;

    // UART receiver
    rx_state_t     rx_state_reg, rx_state_next;
    logic [TW-1:0] rx_cyc_reg, rx_cyc_next;
    logic [2:0]    rx_bit_reg, rx_bit_next;
    logic [7:0]    rx_shift_reg, rx_shift_next;
    logic          rx_push;

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cyc_next   = rx_cyc_reg + 1'b1;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_push       = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                rx_cyc_next = '0;
                if (rx_prev_reg && !rx_sync_reg)
                    rx_state_next = RX_START;
            end
            RX_START: begin
                if (rx_cyc_reg == TW'(HALF_CYC - 1)) begin
                    rx_cyc_next   = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cyc_reg == TW'(BIT_CYC - 1)) begin
                    rx_cyc_next   = '0;
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
                    rx_bit_next   = rx_bit_reg + 3'd1;
                    if (rx_bit_reg == 3'd7)
                        rx_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cyc_reg == TW'(BIT_CYC - 1)) begin
                    rx_state_next = RX_IDLE;
                    rx_push       = rx_sync_reg;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_reg <= RX_IDLE;
            rx_cyc_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_cyc_reg   <= rx_cyc_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
        end
    end

    // RX drain into the LCD word and the receive counters
    logic [7:0]     rx_rd_data, last_byte_reg, rx_count_reg;
    logic [FCW-1:0] rx_level;
    logic [31:0]    lcd_reg;
    logic           rx_pop, rx_pop_d_reg;

    soc_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop), .wr_data(rx_shift_reg),
        .rd_data(rx_rd_data), .count(rx_level), .empty(rx_fifo_empty), .full(rx_fifo_full)
    );

    assign rx_pop = (rx_level != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_pop_d_reg  <= 1'b0;
            lcd_reg       <= '0;
            last_byte_reg <= '0;
            rx_count_reg  <= '0;
        end else begin
            rx_pop_d_reg <= rx_pop;
            if (rx_pop_d_reg) begin
                lcd_reg       <= {lcd_reg[23:0], rx_rd_data};
                last_byte_reg <= rx_rd_data;
                rx_count_reg  <= rx_count_reg + 8'd1;
            end
        end
    end

    assign lcd = lcd_reg;

    // Hex displays, active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
        endcase
    endfunction

    logic [3:0] hex_nib [8];
    logic [6:0] hex_seg [8];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sw_nib
            assign hex_nib[gi] = sw_sync_reg[4*gi +: 4];
        end
        for (gi = 0; gi < 8; gi++) begin : g_hex
            assign hex_seg[gi] = seg7(hex_nib[gi]);
        end
    endgenerate

    assign hex_nib[4] = last_byte_reg[3:0];
    assign hex_nib[5] = last_byte_reg[7:4];
    assign hex_nib[6] = rx_count_reg[3:0];
    assign hex_nib[7] = rx_count_reg[7:4];

    assign hex0 = hex_seg[0];
    assign hex1 = hex_seg[1];
    assign hex2 = hex_seg[2];
    assign hex3 = hex_seg[3];
    assign hex4 = hex_seg[4];
    assign hex5 = hex_seg[5];
    assign hex6 = hex_seg[6];
    assign hex7 = hex_seg[7];
endmodule

// File: tb/tb_soc_top.sv
// Directed bench for soc_top: reset, loopback bursts, button resend, RX framing
// error, and a 4-deep instance that must drain its TX FIFO before each burst.
`timescale 1ns/1ps
module tb_soc_top;
    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int B        = CLK_FREQ / BAUD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] sw, sw2, pc_debug, ledr, ledg, lcd, pc2, ledr2, ledg2, lcd2;
    logic [3:0]  btn, btn2;
    logic        instr_vld, instr2;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [6:0]  h2 [8];
    logic        tx_out, rx_in, loop_en, bench_rx, tx2;
    logic        tx_e, tx_f, rx_e, rx_f, tx_e2, tx_f2, rx_e2, rx_f2;

    assign rx_in = loop_en ? tx_out : bench_rx;

    soc_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn), .pc_debug(pc_debug), .instr_vld(instr_vld),
        .ledr(ledr), .ledg(ledg), .lcd(lcd), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7), .UART_RX_I(rx_in), .UART_TX_O(tx_out),
        .tx_fifo_empty(tx_e), .tx_fifo_full(tx_f), .rx_fifo_empty(rx_e), .rx_fifo_full(rx_f)
    );

    soc_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .sw(sw2), .btn(btn2), .pc_debug(pc2), .instr_vld(instr2),
        .ledr(ledr2), .ledg(ledg2), .lcd(lcd2), .hex0(h2[0]), .hex1(h2[1]), .hex2(h2[2]),
        .hex3(h2[3]), .hex4(h2[4]), .hex5(h2[5]), .hex6(h2[6]), .hex7(h2[7]), .UART_RX_I(tx2),
        .UART_TX_O(tx2), .tx_fifo_empty(tx_e2), .tx_fifo_full(tx_f2), .rx_fifo_empty(rx_e2),
        .rx_fifo_full(rx_f2)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] g(input int n);
        case (n)
            0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;
            3: return 7'b0110000;   4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;   8: return 7'b0000000;
            9: return 7'b0010000;  10: return 7'b0001000;  11: return 7'b0000011;
           12: return 7'b1000110;  13: return 7'b0100001;  14: return 7'b0000110;
           default: return 7'b0001110;
        endcase
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Independent 8N1 decoder on the TX line
    logic       dec_act = 1'b0;
    int         dec_cnt = 0;
    logic [7:0] dec_byte = '0;
    logic [7:0] tx_bytes [$];
    int         tx_starts [$];

    always @(negedge clk) begin
        if (!dec_act) begin
            if (rst_n && tx_out == 1'b0) begin
                dec_act <= 1'b1;
                dec_cnt <= 0;
            end
        end else begin
            dec_cnt <= dec_cnt + 1;
            if ((dec_cnt + 1) % B == B / 2) begin
                if ((dec_cnt + 1) / B >= 1 && (dec_cnt + 1) / B <= 8) begin
                    dec_byte <= {tx_out, dec_byte[7:1]};
                end else if ((dec_cnt + 1) / B == 9) begin
                    dec_act <= 1'b0;
                    if (tx_out) begin
                        tx_bytes.push_back(dec_byte);
                        tx_starts.push_back(cyc - (dec_cnt + 1));
                        $display("tx frame byte %02h started at cycle %0d", dec_byte, cyc - (dec_cnt + 1));
                    end
                end
            end
        end
    end

    // instr_vld burst tracking and full-flag watch
    logic vld_prev = 1'b0;
    int   run_len = 0, last_run = 0, runs = 0;
    logic full_seen = 1'b0;
    always @(negedge clk) begin
        vld_prev <= instr_vld;
        if (instr_vld) begin
            run_len <= run_len + 1;
        end else if (vld_prev) begin
            last_run <= run_len;
            run_len  <= 0;
            runs     <= runs + 1;
        end
        if (tx_f)
            full_seen <= 1'b1;
    end

    // 4-deep instance: each burst may only start once its TX FIFO had fully drained
    logic vld2_prev = 1'b0, empty2_prev = 1'b1;
    int   runs2 = 0, pulses2 = 0;
    always @(negedge clk) begin
        vld2_prev   <= instr2;
        empty2_prev <= tx_e2;
        if (instr2)
            pulses2 <= pulses2 + 1;
        if (instr2 && !vld2_prev) begin
            runs2 <= runs2 + 1;
            check("depth4_burst_after_drain", {63'd0, empty2_prev}, 64'd1);
        end
    end

    task automatic wait_tx(input int n, input string tag);
        int t = 0;
        while (tx_bytes.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(tag, tx_bytes.size(), n);
        repeat (3 * B) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        bench_rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bench_rx = d[i];
            repeat (B) @(negedge clk);
        end
        bench_rx = stop_bit;
        repeat (B) @(negedge clk);
        bench_rx = 1'b1;
        repeat (3 * B) @(negedge clk);
        $display("rx frame byte %02h stop %0b driven", d, stop_bit);
    endtask

    initial begin
        rst_n = 1'b0; sw = 32'd2; btn = 4'd0; sw2 = 32'h11; btn2 = 4'd0;
        loop_en = 1'b1; bench_rx = 1'b1;
        @(posedge clk); @(negedge clk);

        check("rst_pc", pc_debug, 0);
        check("rst_instr_vld", instr_vld, 0);
        check("rst_leds", {ledr, ledg}, 0);
        check("rst_lcd", lcd, 0);
        check("rst_tx_line", tx_out, 1);
        check("rst_fifo_flags", {tx_e, tx_f, rx_e, rx_f}, 4'b1010);
        check("rst_hex", {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0}, {8{g(0)}});
        rst_n = 1'b1;

        @(posedge clk); @(negedge clk); check("ledr_lat1", ledr, 0);
        @(posedge clk); @(negedge clk); check("ledr_lat2", ledr, 0);
        @(posedge clk); @(negedge clk); check("ledr_lat3", ledr, 2);

        // Let the 4-deep instance finish its first burst, then ask for another
        for (int t = 0; t < 50 && pulses2 < 4; t++) @(negedge clk);
        sw2 = 32'h22;

        // First send, sw=2
        wait_tx(4, "burst1_frames");
        check("burst1_runs", runs, 1);
        check("burst1_run_len", last_run, 4);
        check("burst1_pc", pc_debug, 16);
        check("burst1_bytes", {tx_bytes[0], tx_bytes[1], tx_bytes[2], tx_bytes[3]}, 32'h02000000);
        check("burst1_spacing", tx_starts[1] - tx_starts[0], 10 * B);
        check("burst1_total", tx_starts[3] + 10 * B - tx_starts[0], 40 * B);
        check("burst1_lcd", lcd, 32'h02000000);
        check("burst1_hex7_6", {hex7, hex6}, {g(0), g(4)});
        check("burst1_ledr", ledr, 2);
        check("burst1_hex0", hex0, g(2));
        check("burst1_fifos_empty", {tx_e, rx_e}, 2'b11);

        // Switch change triggers a second burst
        sw = 32'hDD123456;
        wait_tx(8, "burst2_frames");
        check("burst2_pc", pc_debug, 32);
        check("burst2_bytes", {tx_bytes[4], tx_bytes[5], tx_bytes[6], tx_bytes[7]}, 32'h563412DD);
        check("burst2_lcd", lcd, 32'h563412DD);
        check("burst2_hex3_0", {hex3, hex2, hex1, hex0}, {g(3), g(4), g(5), g(6)});
        check("burst2_hex7_4", {hex7, hex6, hex5, hex4}, {g(0), g(8), g(13), g(13)});

        // Button edge with unchanged switches
        btn = 4'd1;
        repeat (3) @(negedge clk);
        check("ledg_btn", ledg, 1);
        repeat (2) @(negedge clk);
        btn = 4'd0;
        wait_tx(12, "burst3_frames");
        check("burst3_pc", pc_debug, 48);
        check("burst3_runs", runs, 3);
        check("burst3_run_len", last_run, 4);
        check("burst3_bytes", {tx_bytes[8], tx_bytes[9], tx_bytes[10], tx_bytes[11]}, 32'h563412DD);
        repeat (30 * B) @(negedge clk);
        check("no_change_no_send", {runs[31:0], pc_debug}, {32'd3, 32'd48});

        // Framing error then a good frame, loopback broken
        loop_en = 1'b0;
        send_frame(8'h3C, 1'b0);
        check("framing_lcd", lcd, 32'h563412DD);
        check("framing_hex7_6", {hex7, hex6}, {g(0), g(12)});
        send_frame(8'hA5, 1'b1);
        check("good_hex5_4", {hex5, hex4}, {g(10), g(5)});
        check("good_lcd", lcd, 32'h3412DDA5);
        check("good_hex7_6", {hex7, hex6}, {g(0), g(13)});

        // FIFO boundaries
        for (int t = 0; t < 1000 && pulses2 < 8; t++) @(negedge clk);
        check("depth4_pulses", pulses2, 8);
        check("depth4_runs", runs2, 2);
        check("depth8_never_full", full_seen, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
